// File: rtl/addr_gen_2d.sv
// addr_gen_2d: two-level (inner/outer) strided address generator with a
// valid/ready output handshake, one-shot or continuous (wrap) walks and a
// synchronous abort.
// Optional build macro ADDR_GEN_BOUNDS_CHECK_EN adds limit_addr/bound_err,
// a sticky flag raised when a presented address exceeds a latched limit.
module addr_gen_2d #(
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  wrap_mode,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  inner_last_idx,
    input  logic [ADDR_WIDTH-1:0] inner_stride,
    input  logic [CNT_WIDTH-1:0]  outer_last_idx,
    input  logic [ADDR_WIDTH-1:0] outer_stride,
`ifdef ADDR_GEN_BOUNDS_CHECK_EN
    input  logic [ADDR_WIDTH-1:0] limit_addr,
    output logic                  bound_err,
`endif
    input  logic                  addr_ready,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  addr_valid,
    output logic                  inner_last,
    output logic                  last,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [ADDR_WIDTH-1:0] row_base_reg, row_base_next;
    logic [CNT_WIDTH-1:0]  inner_idx_reg, inner_idx_next;
    logic [CNT_WIDTH-1:0]  outer_idx_reg, outer_idx_next;
    logic                  done_reg, done_next;

    // Configuration captured at start so the sequencer may change its inputs mid-walk.
    logic                  wrap_reg, wrap_next;
    logic [ADDR_WIDTH-1:0] base_reg, base_next;
    logic [CNT_WIDTH-1:0]  inner_lim_reg, inner_lim_next;
    logic [ADDR_WIDTH-1:0] inner_stride_reg, inner_stride_next;
    logic [CNT_WIDTH-1:0]  outer_lim_reg, outer_lim_next;
    logic [ADDR_WIDTH-1:0] outer_stride_reg, outer_stride_next;

    logic                  run;
    logic                  row_end;
    logic                  walk_end;

    assign run      = (state_reg == RUN);
    assign row_end  = (inner_idx_reg == inner_lim_reg);
    assign walk_end = row_end && (outer_idx_reg == outer_lim_reg);

    assign addr       = addr_reg;
    assign addr_valid = run;
    assign busy       = run;
    assign inner_last = run && row_end;
    assign last       = run && walk_end;
    assign done       = done_reg;

    // Next-state, address stepping and config capture.
    always_comb begin
        state_next        = state_reg;
        addr_next         = addr_reg;
        row_base_next     = row_base_reg;
        inner_idx_next    = inner_idx_reg;
        outer_idx_next    = outer_idx_reg;
        done_next         = 1'b0;
        wrap_next         = wrap_reg;
        base_next         = base_reg;
        inner_lim_next    = inner_lim_reg;
        inner_stride_next = inner_stride_reg;
        outer_lim_next    = outer_lim_reg;
        outer_stride_next = outer_stride_reg;
        case (state_reg)
            IDLE: begin
                // stop beats a same-cycle start
                if (start && !stop) begin
                    wrap_next         = wrap_mode;
                    base_next         = base_addr;
                    inner_lim_next    = inner_last_idx;
                    inner_stride_next = inner_stride;
                    outer_lim_next    = outer_last_idx;
                    outer_stride_next = outer_stride;
                    addr_next         = base_addr;
                    row_base_next     = base_addr;
                    inner_idx_next    = '0;
                    outer_idx_next    = '0;
                    state_next        = RUN;
                end
            end
            RUN: begin
                // stop wins over a handshake in the same cycle: no advance, no done
                if (stop) begin
                    state_next = IDLE;
                end else if (addr_ready) begin
                    if (inner_idx_reg < inner_lim_reg) begin
                        inner_idx_next = inner_idx_reg + CNT_WIDTH'(1);
                        addr_next      = addr_reg + inner_stride_reg;
                    end else if (outer_idx_reg < outer_lim_reg) begin
                        inner_idx_next = '0;
                        outer_idx_next = outer_idx_reg + CNT_WIDTH'(1);
                        row_base_next  = row_base_reg + outer_stride_reg;
                        addr_next      = row_base_reg + outer_stride_reg;
                    end else begin
                        done_next = 1'b1;
                        if (wrap_reg) begin
                            addr_next      = base_reg;
                            row_base_next  = base_reg;
                            inner_idx_next = '0;
                            outer_idx_next = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            addr_reg         <= '0;
            row_base_reg     <= '0;
            inner_idx_reg    <= '0;
            outer_idx_reg    <= '0;
            done_reg         <= 1'b0;
            wrap_reg         <= 1'b0;
            base_reg         <= '0;
            inner_lim_reg    <= '0;
            inner_stride_reg <= '0;
            outer_lim_reg    <= '0;
            outer_stride_reg <= '0;
        end else begin
            state_reg        <= state_next;
            addr_reg         <= addr_next;
            row_base_reg     <= row_base_next;
            inner_idx_reg    <= inner_idx_next;
            outer_idx_reg    <= outer_idx_next;
            done_reg         <= done_next;
            wrap_reg         <= wrap_next;
            base_reg         <= base_next;
            inner_lim_reg    <= inner_lim_next;
            inner_stride_reg <= inner_stride_next;
            outer_lim_reg    <= outer_lim_next;
            outer_stride_reg <= outer_stride_next;
        end
    end

`ifdef ADDR_GEN_BOUNDS_CHECK_EN
    logic [ADDR_WIDTH-1:0] limit_reg;
    logic                  err_reg;
    logic                  over_limit;

    // The current out-of-range address is flagged immediately; the register keeps it sticky.
    assign over_limit = run && (addr_reg > limit_reg);
    assign bound_err  = err_reg || over_limit;

    // Limit capture and sticky error; an accepted start clears the flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            limit_reg <= '0;
            err_reg   <= 1'b0;
        end else if (!run && start && !stop) begin
            limit_reg <= limit_addr;
            err_reg   <= 1'b0;
        end else begin
            err_reg   <= err_reg || over_limit;
        end
    end
`endif

endmodule

// File: tb/tb_addr_gen_2d.sv
// tb_addr_gen_2d: directed scenarios followed by randomized traffic, all
// checked every cycle against a loop-index reference model that computes each
// address as base + outer*outer_stride + inner*inner_stride (mod 256).
// Build with ADDR_GEN_BOUNDS_CHECK_EN defined to also exercise bound_err.
module tb_addr_gen_2d;

    logic       clk = 1'b0;
    logic       rst, start, stop, wrap_mode, addr_ready;
    logic [7:0] base_addr, inner_stride, outer_stride;
    logic [3:0] inner_last_idx, outer_last_idx;
    logic [7:0] addr;
    logic       addr_valid, inner_last, last, busy, done;
`ifdef ADDR_GEN_BOUNDS_CHECK_EN
    logic [7:0] limit_addr;
    logic       bound_err;
`endif

    addr_gen_2d #(.ADDR_WIDTH(8), .CNT_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .wrap_mode(wrap_mode),
        .base_addr(base_addr), .inner_last_idx(inner_last_idx),
        .inner_stride(inner_stride), .outer_last_idx(outer_last_idx),
        .outer_stride(outer_stride),
`ifdef ADDR_GEN_BOUNDS_CHECK_EN
        .limit_addr(limit_addr), .bound_err(bound_err),
`endif
        .addr_ready(addr_ready), .addr(addr), .addr_valid(addr_valid),
        .inner_last(inner_last), .last(last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bit       m_run, m_done, m_wrap;
    int       m_i, m_o, c_il, c_ol;
    int       c_base, c_is, c_os;
    logic [7:0] m_addr;
`ifdef ADDR_GEN_BOUNDS_CHECK_EN
    bit       m_err;
    logic [7:0] c_lim;
`endif

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_addr(input int i, input int o);
        int s;
        s = (c_base + o * c_os + i * c_is) % 256;
        return s[7:0];
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        bit was_run;
        was_run = m_run;
`ifdef ADDR_GEN_BOUNDS_CHECK_EN
        if (!rst) begin
            if (!m_run && start && !stop) m_err = 0;
            else m_err = m_err || (m_run && (m_addr > c_lim));
        end
`endif
        if (rst) begin
            m_run = 0; m_done = 0; m_wrap = 0; m_i = 0; m_o = 0;
            c_il = 0; c_ol = 0; c_base = 0; c_is = 0; c_os = 0; m_addr = 8'h00;
`ifdef ADDR_GEN_BOUNDS_CHECK_EN
            m_err = 0; c_lim = 8'h00;
`endif
        end else if (!m_run) begin
            m_done = 0;
            if (start && !stop) begin
                c_base = int'(base_addr); c_is = int'(inner_stride); c_os = int'(outer_stride);
                c_il = int'(inner_last_idx); c_ol = int'(outer_last_idx); m_wrap = wrap_mode;
`ifdef ADDR_GEN_BOUNDS_CHECK_EN
                c_lim = limit_addr;
`endif
                m_i = 0; m_o = 0; m_run = 1;
            end
        end else begin
            m_done = 0;
            if (stop) begin
                m_run = 0;
            end else if (addr_ready) begin
                $display("xfer addr=0x%02h row=%0d col=%0d", m_addr, m_o, m_i);
                if (m_i < c_il) m_i++;
                else if (m_o < c_ol) begin m_i = 0; m_o++; end
                else begin
                    m_done = 1;
                    m_i = 0; m_o = 0;
                    if (!m_wrap) m_run = 0;
                end
            end
        end
        if (m_run) m_addr = model_addr(m_i, m_o);
        else if (was_run && !rst && m_done) m_addr = model_addr(c_il, c_ol);
    endtask

    task automatic check_outputs();
        bit exp_il;
        exp_il = m_run && (m_i == c_il);
        check_val("addr_valid", 32'(addr_valid), 32'(m_run));
        check_val("busy", 32'(busy), 32'(m_run));
        check_val("addr", 32'(addr), 32'(m_addr));
        check_val("inner_last", 32'(inner_last), 32'(exp_il));
        check_val("last", 32'(last), 32'(exp_il && (m_o == c_ol)));
        check_val("done", 32'(done), 32'(m_done));
`ifdef ADDR_GEN_BOUNDS_CHECK_EN
        check_val("bound_err", 32'(bound_err), 32'(m_err || (m_run && (m_addr > c_lim))));
`endif
    endtask

    // One clock: check current outputs, take the edge, update the model.
    task automatic cycle();
        check_outputs();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_cfg(input logic [7:0] b, input logic [3:0] il, input logic [7:0] is_,
                           input logic [3:0] ol, input logic [7:0] os, input logic w);
        base_addr = b; inner_last_idx = il; inner_stride = is_;
        outer_last_idx = ol; outer_stride = os; wrap_mode = w;
    endtask

    task automatic pulse_start();
        start = 1'b1; cycle(); start = 1'b0;
    endtask

    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; addr_ready = 1'b0;
        set_cfg(8'h00, 4'd0, 8'h00, 4'd0, 8'h00, 1'b0);
`ifdef ADDR_GEN_BOUNDS_CHECK_EN
        limit_addr = 8'hFF;
`endif
        @(posedge clk); model_step(); #1;
        cycle();                      // reset state checked here
        rst = 1'b0;

        // One-shot 2x3
        addr_ready = 1'b1;
        set_cfg(8'h10, 4'd2, 8'h01, 4'd1, 8'h10, 1'b0);
`ifdef ADDR_GEN_BOUNDS_CHECK_EN
        limit_addr = 8'h20;
`endif
        pulse_start();
        set_cfg(8'hAA, 4'd5, 8'h05, 4'd5, 8'h05, 1'b1);  // ignored while running
        run_cycles(8);

        // Backpressure: ready pattern 1,0,0,1 repeated
        set_cfg(8'h10, 4'd2, 8'h01, 4'd1, 8'h10, 1'b0);
        pulse_start();
        for (int k = 0; k < 16; k++) begin
            addr_ready = (k % 4 == 0) || (k % 4 == 3);
            cycle();
        end
        addr_ready = 1'b1;
        run_cycles(2);

        // Wrap across the address-space boundary, then abort
        set_cfg(8'hFE, 4'd3, 8'h01, 4'd0, 8'h00, 1'b1);
        pulse_start();
        run_cycles(6);
        stop = 1'b1; cycle(); stop = 1'b0;
        run_cycles(2);

        // Single element; start while busy ignored (stall first)
        set_cfg(8'h42, 4'd0, 8'h07, 4'd0, 8'h09, 1'b0);
        addr_ready = 1'b0;
        pulse_start();
        set_cfg(8'h99, 4'd1, 8'h01, 4'd1, 8'h01, 1'b0);
        start = 1'b1; cycle(); start = 1'b0;
        addr_ready = 1'b1;
        run_cycles(3);

        // stop and start together in IDLE
        start = 1'b1; stop = 1'b1; cycle(); start = 1'b0; stop = 1'b0;
        run_cycles(1);

        // Reset mid-walk during the third address
        set_cfg(8'h30, 4'd3, 8'h02, 4'd1, 8'h20, 1'b0);
        pulse_start();
        run_cycles(2);
        rst = 1'b1; cycle(); rst = 1'b0;
        run_cycles(1);
        set_cfg(8'h50, 4'd1, 8'h01, 4'd1, 8'h08, 1'b0);
        pulse_start();
        run_cycles(6);

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            rst        = ($urandom_range(0, 99) == 0);
            stop       = ($urandom_range(0, 39) == 0);
            start      = ($urandom_range(0, 3) == 0);
            addr_ready = ($urandom_range(0, 9) < 7);
            set_cfg(8'($urandom), 4'($urandom_range(0, 3)), 8'($urandom),
                    4'($urandom_range(0, 3)), 8'($urandom), 1'($urandom_range(0, 1)));
`ifdef ADDR_GEN_BOUNDS_CHECK_EN
            limit_addr = 8'($urandom);
`endif
            cycle();
        end
        rst = 1'b0; stop = 1'b0; start = 1'b0;
        check_outputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
